// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers.
// pix_addr is present only when VGA_PIXEL_ADDR_EN is defined.
interface vga_timing_gen_if #(
   parameter int CW = 10
`ifdef VGA_PIXEL_ADDR_EN
   ,
   parameter int ADDR_W = 19
`endif
);
   logic          hsync;
   logic          vsync;
   logic          vidon;
   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic [CW-1:0] px_x;
   logic [CW-1:0] px_y;
   logic          line_start;
   logic          frame_start;
`ifdef VGA_PIXEL_ADDR_EN
   logic [ADDR_W-1:0] pix_addr;
`endif

   modport master (
      output hsync, vsync, vidon, hc, vc, px_x, px_y, line_start, frame_start
`ifdef VGA_PIXEL_ADDR_EN
      , output pix_addr
`endif
   );

   modport slave (
      input hsync, vsync, vidon, hc, vc, px_x, px_y, line_start, frame_start
`ifdef VGA_PIXEL_ADDR_EN
      , input pix_addr
`endif
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator, all outputs registered from next counter values.
// Optional linear pixel address output enabled by defining VGA_PIXEL_ADDR_EN.
module vga_timing_gen #(
   parameter int   CW     = 10,
   parameter int   H_SYNC = 128,
   parameter int   H_BP   = 16,
   parameter int   H_ACT  = 640,
   parameter int   H_FP   = 16,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 29,
   parameter int   V_ACT  = 480,
   parameter int   V_FP   = 10,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0
`ifdef VGA_PIXEL_ADDR_EN
   ,
   parameter int   ADDR_W = 19
`endif
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                ce,
   vga_timing_gen_if.master    vga
);
   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

   localparam logic [CW-1:0] L_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] L_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] L_H_MAX  = CW'(H_TOT - 1);
   localparam logic [CW-1:0] L_V_MAX  = CW'(V_TOT - 1);
   localparam logic [CW-1:0] L_HA_OFF = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] L_VA_OFF = CW'(V_SYNC + V_BP);
   // Window bounds carry one extra bit so an end at 2**CW does not alias to zero.
   localparam logic [CW:0]   L_H_SYNC = (CW+1)'(H_SYNC);
   localparam logic [CW:0]   L_HA_BEG = (CW+1)'(H_SYNC + H_BP);
   localparam logic [CW:0]   L_HA_END = (CW+1)'(H_SYNC + H_BP + H_ACT);
   localparam logic [CW:0]   L_V_SYNC = (CW+1)'(V_SYNC);
   localparam logic [CW:0]   L_VA_BEG = (CW+1)'(V_SYNC + V_BP);
   localparam logic [CW:0]   L_VA_END = (CW+1)'(V_SYNC + V_BP + V_ACT);

   logic [CW-1:0] r_hc;
   logic [CW-1:0] r_vc;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_vidon;
   logic [CW-1:0] r_px_x;
   logic [CW-1:0] r_px_y;
   logic          r_line_start;
   logic          r_frame_start;

   logic          w_hc_wrap;
   logic [CW-1:0] w_hc_nxt;
   logic [CW-1:0] w_vc_nxt;
   logic          w_h_act;
   logic          w_v_act;
   logic          w_vidon_nxt;
   logic          w_hsync_nxt;
   logic          w_vsync_nxt;
   logic [CW-1:0] w_px_x_nxt;
   logic [CW-1:0] w_px_y_nxt;
   logic          w_line_nxt;
   logic          w_frame_nxt;

   // Next counter position and every output decoded from it.
   always_comb begin
      w_hc_wrap = (r_hc == L_H_MAX);
      if (w_hc_wrap) begin
         w_hc_nxt = L_ZERO;
         w_vc_nxt = (r_vc == L_V_MAX) ? L_ZERO : (r_vc + L_ONE);
      end else begin
         w_hc_nxt = r_hc + L_ONE;
         w_vc_nxt = r_vc;
      end
      w_h_act     = ({1'b0, w_hc_nxt} >= L_HA_BEG) && ({1'b0, w_hc_nxt} < L_HA_END);
      w_v_act     = ({1'b0, w_vc_nxt} >= L_VA_BEG) && ({1'b0, w_vc_nxt} < L_VA_END);
      w_vidon_nxt = w_h_act && w_v_act;
      w_hsync_nxt = ({1'b0, w_hc_nxt} < L_H_SYNC) ? H_POL : ~H_POL;
      w_vsync_nxt = ({1'b0, w_vc_nxt} < L_V_SYNC) ? V_POL : ~V_POL;
      if (w_vidon_nxt) begin
         w_px_x_nxt = w_hc_nxt - L_HA_OFF;
         w_px_y_nxt = w_vc_nxt - L_VA_OFF;
      end else begin
         w_px_x_nxt = L_ZERO;
         w_px_y_nxt = L_ZERO;
      end
      w_line_nxt  = (w_hc_nxt == L_ZERO);
      w_frame_nxt = w_line_nxt && (w_vc_nxt == L_ZERO);
   end

   // Timing registers; strobes self-clear on idle clocks while the rest hold.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_hc          <= L_H_MAX;
         r_vc          <= L_V_MAX;
         r_hsync       <= ~H_POL;
         r_vsync       <= ~V_POL;
         r_vidon       <= 1'b0;
         r_px_x        <= L_ZERO;
         r_px_y        <= L_ZERO;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (ce) begin
         r_hc          <= w_hc_nxt;
         r_vc          <= w_vc_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_vidon       <= w_vidon_nxt;
         r_px_x        <= w_px_x_nxt;
         r_px_y        <= w_px_y_nxt;
         r_line_start  <= w_line_nxt;
         r_frame_start <= w_frame_nxt;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign vga.hc          = r_hc;
   assign vga.vc          = r_vc;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.vidon       = r_vidon;
   assign vga.px_x        = r_px_x;
   assign vga.px_y        = r_px_y;
   assign vga.line_start  = r_line_start;
   assign vga.frame_start = r_frame_start;

`ifdef VGA_PIXEL_ADDR_EN
   localparam logic [ADDR_W-1:0] L_A_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] L_A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] r_pix_addr;

   // Step past each displayed pixel so blanking holds the next active address.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_pix_addr <= L_A_ZERO;
      end else if (ce) begin
         if (w_frame_nxt) begin
            r_pix_addr <= L_A_ZERO;
         end else if (r_vidon) begin
            r_pix_addr <= r_pix_addr + L_A_ONE;
         end else begin
            r_pix_addr <= r_pix_addr;
         end
      end else begin
         r_pix_addr <= r_pix_addr;
      end
   end

   assign vga.pix_addr = r_pix_addr;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-geometry DUT for sync/active placement, small DUT for frame-level behaviour.
module tb_vga_timing_gen;
   logic clk;
   logic clr_n;
   logic ce_d;
   logic ce_s;
   int   n_checks;
   int   n_errors;

   vga_timing_gen_if #(.CW(10)) d_if ();
   vga_timing_gen_if #(.CW(6))  s_if ();

   vga_timing_gen u_dut_d (
      .clk   (clk),
      .clr_n (clr_n),
      .ce    (ce_d),
      .vga   (d_if.master)
   );

   // Small geometry: H 3/2/6/1 (tot 12), V 1/2/4/1 (tot 8), active-high syncs.
   vga_timing_gen #(
      .CW(6), .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(1),
      .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1), .H_POL(1'b1), .V_POL(1'b1)
   ) u_dut_s (
      .clk   (clk),
      .clr_n (clr_n),
      .ce    (ce_s),
      .vga   (s_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int vid_cnt;
      int fs_cnt;
      int ph;
      int pv;
      int h;
      int v;
      logic exp_vid;
      logic reached;
      n_checks = 0;
      n_errors = 0;
      clr_n = 1'b0;
      ce_d  = 1'b1;
      ce_s  = 1'b0;
      #12;
      chk("d_rst_hc", d_if.hc, 32'd799);
      chk("d_rst_vc", d_if.vc, 32'd520);
      chk("d_rst_hsync", d_if.hsync, 32'd1);
      chk("d_rst_vsync", d_if.vsync, 32'd1);
      chk("d_rst_vidon", d_if.vidon, 32'd0);
      chk("d_rst_fs", d_if.frame_start, 32'd0);
      clr_n = 1'b1;

      tick();
      chk("d_first_hc", d_if.hc, 32'd0);
      chk("d_first_vc", d_if.vc, 32'd0);
      chk("d_first_ls", d_if.line_start, 32'd1);
      chk("d_first_fs", d_if.frame_start, 32'd1);
      chk("d_first_hsync", d_if.hsync, 32'd0);
      chk("d_first_vsync", d_if.vsync, 32'd0);
      tick();
      chk("d_second_ls", d_if.line_start, 32'd0);
      chk("d_second_fs", d_if.frame_start, 32'd0);

      for (int i = 0; i < 200 && d_if.hc != 10'd127; i++) tick();
      chk("d_reach_127", d_if.hc, 32'd127);
      chk("d_hsync_127", d_if.hsync, 32'd0);
      tick();
      chk("d_hsync_128", d_if.hsync, 32'd1);

      reached = 1'b0;
      for (int i = 0; i < 30000 && !reached; i++) begin
         if (d_if.hc == 10'd143 && d_if.vc == 10'd31) reached = 1'b1;
         else tick();
      end
      chk("d_reach_143_31", reached, 32'd1);
      chk("d_vidon_143", d_if.vidon, 32'd0);
      tick();
      chk("d_act_hc", d_if.hc, 32'd144);
      chk("d_vidon_144", d_if.vidon, 32'd1);
      chk("d_px_x_first", d_if.px_x, 32'd0);
      chk("d_px_y_first", d_if.px_y, 32'd0);
      chk("d_vsync_31", d_if.vsync, 32'd1);

      for (int i = 0; i < 1000 && d_if.hc != 10'd799; i++) tick();
      chk("d_reach_799", d_if.hc, 32'd799);
      chk("d_vc_at_799", d_if.vc, 32'd31);
      tick();
      chk("d_wrap_hc", d_if.hc, 32'd0);
      chk("d_wrap_vc", d_if.vc, 32'd32);
      chk("d_wrap_ls", d_if.line_start, 32'd1);

      // Small DUT has been held by ce=0 since reset release.
      chk("s_hold_hc", s_if.hc, 32'd11);
      chk("s_hold_vc", s_if.vc, 32'd7);
      chk("s_hold_hsync", s_if.hsync, 32'd0);
      chk("s_hold_vsync", s_if.vsync, 32'd0);

      ce_s = 1'b1;
      tick();
      chk("s_first_hc", s_if.hc, 32'd0);
      chk("s_first_vc", s_if.vc, 32'd0);
      chk("s_first_fs", s_if.frame_start, 32'd1);
      chk("s_first_hsync", s_if.hsync, 32'd1);
      chk("s_first_vsync", s_if.vsync, 32'd1);
`ifdef VGA_PIXEL_ADDR_EN
      chk("s_first_addr", s_if.pix_addr, 32'd0);
`endif

      vid_cnt = 0;
      fs_cnt  = 0;
      for (int i = 1; i < 96; i++) begin
         ph = int'(s_if.hc);
         pv = int'(s_if.vc);
         tick();
         h = int'(s_if.hc);
         v = int'(s_if.vc);
         if (s_if.vidon) vid_cnt++;
         if (s_if.frame_start) fs_cnt++;
         exp_vid = (h >= 5 && h < 11 && v >= 3 && v < 7);
         chk("s_vidon", s_if.vidon, exp_vid);
         chk("s_hsync", s_if.hsync, (h < 3) ? 32'd1 : 32'd0);
         chk("s_px_x", s_if.px_x, exp_vid ? h - 5 : 0);
         chk("s_px_y", s_if.px_y, exp_vid ? v - 3 : 0);
         if (ph == 11) begin
            chk("s_wrap_hc", s_if.hc, 32'd0);
            chk("s_wrap_vc", s_if.vc, pv + 1);
            chk("s_wrap_ls", s_if.line_start, 32'd1);
         end
`ifdef VGA_PIXEL_ADDR_EN
         if (exp_vid) chk("s_addr_act", s_if.pix_addr, (v - 3) * 6 + (h - 5));
         if (h == 11 && v == 6) chk("s_addr_hold", s_if.pix_addr, 32'd24);
`endif
      end
      chk("s_vid_count", vid_cnt, 32'd24);
      chk("s_fs_inframe", fs_cnt, 32'd0);
      chk("s_end_hc", s_if.hc, 32'd11);
      chk("s_end_vc", s_if.vc, 32'd7);
      tick();
      chk("s_frame2_hc", s_if.hc, 32'd0);
      chk("s_frame2_vc", s_if.vc, 32'd0);
      chk("s_frame2_fs", s_if.frame_start, 32'd1);
`ifdef VGA_PIXEL_ADDR_EN
      chk("s_frame2_addr", s_if.pix_addr, 32'd0);
`endif

      ce_s = 1'b0;
      tick();
      chk("s_ce0_hc", s_if.hc, 32'd0);
      chk("s_ce0_fs_clr", s_if.frame_start, 32'd0);
      chk("s_ce0_ls_clr", s_if.line_start, 32'd0);
      chk("s_ce0_hsync", s_if.hsync, 32'd1);
      tick();
      chk("s_ce0_hc2", s_if.hc, 32'd0);
      ce_s = 1'b1;
      tick();
      chk("s_ce1_hc", s_if.hc, 32'd1);
      ce_s = 1'b0;
      tick();
      chk("s_ce0_hc3", s_if.hc, 32'd1);
      ce_s = 1'b1;
      for (int i = 0; i < 20 && s_if.hc != 6'd11; i++) tick();
      chk("s_reach_11", s_if.hc, 32'd11);
      tick();
      chk("s_tog_hc", s_if.hc, 32'd0);
      chk("s_tog_vc", s_if.vc, 32'd1);
      chk("s_tog_ls", s_if.line_start, 32'd1);
      chk("s_tog_vsync", s_if.vsync, 32'd0);
      ce_s = 1'b0;
      tick();
      chk("s_tog_ls_clr", s_if.line_start, 32'd0);
      chk("s_tog_hold_vc", s_if.vc, 32'd1);
      tick();
      chk("s_tog_ls_stay", s_if.line_start, 32'd0);

      ce_s = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         if (s_if.hc == 6'd6 && s_if.vc == 6'd4) reached = 1'b1;
         else tick();
      end
      chk("s_reach_mid", reached, 32'd1);
      chk("s_mid_vidon", s_if.vidon, 32'd1);
      chk("s_mid_px_x", s_if.px_x, 32'd1);
`ifdef VGA_PIXEL_ADDR_EN
      chk("s_mid_addr", s_if.pix_addr, 32'd7);
`endif
      #1;
      clr_n = 1'b0;
      #1;
      chk("s_arst_hc", s_if.hc, 32'd11);
      chk("s_arst_vc", s_if.vc, 32'd7);
      chk("s_arst_vidon", s_if.vidon, 32'd0);
      chk("s_arst_px_x", s_if.px_x, 32'd0);
      chk("s_arst_hsync", s_if.hsync, 32'd0);
`ifdef VGA_PIXEL_ADDR_EN
      chk("s_arst_addr", s_if.pix_addr, 32'd0);
`endif
      #1;
      clr_n = 1'b1;
      tick();
      chk("s_rel_hc", s_if.hc, 32'd0);
      chk("s_rel_vc", s_if.vc, 32'd0);
      chk("s_rel_fs", s_if.frame_start, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
